// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 frames, LSB first, one bit per TICKS_PER_BIT clocks.
// A one-entry holding register lets the host queue the next byte so frames go out gap-free.
module uart_tx #(
   parameter int unsigned TICKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS     = 1
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       TX,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned   TW          = $clog2(TICKS_PER_BIT);
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICKS_PER_BIT - 1);
   localparam logic [TW-1:0] TICK_PENULT = TW'(TICKS_PER_BIT - 2);
   localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        state_q;
   logic [TW-1:0] tick_q;
   logic [2:0]    bit_q;
   logic          stop_q;
   logic [7:0]    shift_q;
   logic [7:0]    hold_q;
   logic          hold_full_q;

   logic tick_end;
   logic frame_end;
   logic accept;
   logic load;

   assign tick_end   = (tick_q == TICK_LAST);
   assign frame_end  = (state_q == StStop) && tick_end && (stop_q == STOP_LAST);
   assign accept     = data_valid && !hold_full_q;
   assign load       = hold_full_q && ((state_q == StIdle) || frame_end);
   assign data_ready = ~hold_full_q;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         tick_q      <= '0;
         bit_q       <= '0;
         stop_q      <= 1'b0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         TX          <= 1'b1;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         // A load and an accept can never coincide: accept needs the hold empty.
         if (load) begin
            hold_full_q <= 1'b0;
         end else if (accept) begin
            hold_full_q <= 1'b1;
            hold_q      <= data_in;
         end

         tx_done <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (hold_full_q) begin
                  state_q <= StStart;
                  shift_q <= hold_q;
                  tick_q  <= '0;
                  TX      <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            StStart: begin
               if (tick_end) begin
                  state_q <= StData;
                  tick_q  <= '0;
                  bit_q   <= '0;
                  TX      <= shift_q[0];
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            StData: begin
               if (tick_end) begin
                  tick_q <= '0;
                  bit_q  <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= StStop;
                     stop_q  <= 1'b0;
                     TX      <= 1'b1;
                  end else begin
                     shift_q <= shift_q >> 1;
                     TX      <= shift_q[1];
                  end
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            StStop: begin
               // Registered pulse: raise it one edge early so it lands on the final stop cycle.
               if ((tick_q == TICK_PENULT) && (stop_q == STOP_LAST)) begin
                  tx_done <= 1'b1;
               end
               if (tick_end) begin
                  tick_q <= '0;
                  if (stop_q != STOP_LAST) begin
                     stop_q <= 1'b1;
                  end else if (hold_full_q) begin
                     state_q <= StStart;
                     shift_q <= hold_q;
                     TX      <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                     tx_busy <= 1'b0;
                  end
               end else begin
                  tick_q <= tick_q + TW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
